mem_digital_reader: RTL

MEM_DIGITAL_READER -- requirements
Module: mem_digital_reader

---
 rtl/mem_digital_reader_pkg.sv | 13 +
 rtl/mem_digital_ram.sv | 30 +++
 rtl/mem_digital_reader.sv | 85 ++++++++
 3 files changed

// File: rtl/mem_digital_reader_pkg.sv
// Shared definitions for the mem_digital_reader capture buffer.
// op_t names what the buffer does on a clock edge, given the accepted write
// and pop strobes.
package mem_digital_reader_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_POP   = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } op_t;

endpackage

// File: rtl/mem_digital_ram.sv
// Storage array for the capture buffer.
// Simple dual-port RAM: synchronous write, asynchronous read.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write index
//   wdata - write data
//   raddr - read index
//   rdata - read data (combinational from raddr)
module mem_digital_ram #(
  parameter int unsigned width = 1,
  parameter int unsigned depth = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(depth)-1:0] waddr,
  input  logic [width-1:0]         wdata,
  input  logic [$clog2(depth)-1:0] raddr,
  output logic [width-1:0]         rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_digital_reader.sv
// Digital capture buffer: samples `in` on every cycle with cke=1 and queues
// the samples in a first-word-fall-through FIFO that the host drains.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset (clears pointers, count, overflow)
//   cke      - offer a sample of `in` this cycle
//   in       - sampled value
//   rd_ready - host consumes the head entry this cycle
//   rd_valid - head entry available (count > 0)
//   rd_data  - head entry, or `init` when empty
//   count    - number of stored entries, 0..depth
//   overflow - sticky: at least one offered sample was dropped
module mem_digital_reader
  import mem_digital_reader_pkg::*;
#(
  parameter int unsigned      width = 1,
  parameter int unsigned      depth = 16,
  parameter logic [width-1:0] init  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cke,
  input  logic [width-1:0]           in,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [width-1:0]           rd_data,
  output logic [$clog2(depth+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cnt_w = $clog2(depth + 1);

  logic [ptr_w-1:0] head;
  logic [ptr_w-1:0] tail;
  logic [width-1:0] ram_rdata;
  logic             full;
  logic             pop;
  logic             wr;
  op_t              op;

  assign rd_valid = (count != '0);
  assign full     = (count == cnt_w'(depth));
  assign pop      = rd_valid & rd_ready;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign wr       = cke & (~full | pop);
  assign rd_data  = rd_valid ? ram_rdata : init;

  always_comb begin
    op = op_t'({wr, pop});
  end

  // Writes are gated by rst so a sample offered during reset never lands.
  mem_digital_ram #(
    .width(width),
    .depth(depth)
  ) u_ram (
    .clk  (clk),
    .we   (wr & ~rst),
    .waddr(tail),
    .wdata(in),
    .raddr(head),
    .rdata(ram_rdata)
  );

  // Pointers wrap naturally at ptr_w bits; count disambiguates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  tail <= tail + ptr_w'(1);
      if (pop) head <= head + ptr_w'(1);
      unique case (op)
        OP_WRITE: count <= count + cnt_w'(1);
        OP_POP:   count <= count - cnt_w'(1);
        default:  ;
      endcase
      if (cke && full && !pop) overflow <= 1'b1;
    end
  end

endmodule
